// File: rtl/icache_data_arb_pkg.sv
// Shared types for the instruction-cache data RAM arbiter.
package icache_data_arb_pkg;

    // Top-level sequencer states: zeroing sweep or normal arbitration.
    typedef enum logic [0:0] {
        S_INIT = 1'b0,
        S_ARB  = 1'b1
    } arb_state_e;

    // Width of the consecutive-write counter (MAX_WR_STREAK <= 15).
    localparam int STREAK_W = 4;

endpackage

// File: rtl/icache_data_ram_arb.sv
// Arbiter/sequencer for one single-port L1.5 icache data RAM bank.
// Writes (refill) win over reads (lookup), except that a pending read is
// guaranteed a slot after MAX_WR_STREAK consecutive write grants. After
// reset, or on init_i, the whole bank is swept to zero before any grant.
module icache_data_ram_arb
    import icache_data_arb_pkg::*;
#(
    parameter int DATA_WIDTH    = 64,
    parameter int ADDR_WIDTH    = 7,
    parameter int BE_WIDTH      = DATA_WIDTH / 8,
    parameter int MAX_WR_STREAK = 4
) (
    input  logic                  clk,
    input  logic                  rst,

    input  logic                  init_i,
    output logic                  init_busy_o,

    input  logic                  rd_req_i,
    input  logic [ADDR_WIDTH-1:0] rd_addr_i,
    output logic                  rd_gnt_o,
    output logic                  rd_rvalid_o,
    output logic [DATA_WIDTH-1:0] rd_rdata_o,

    input  logic                  wr_req_i,
    input  logic [ADDR_WIDTH-1:0] wr_addr_i,
    input  logic [DATA_WIDTH-1:0] wr_wdata_i,
    input  logic [BE_WIDTH-1:0]   wr_be_i,
    output logic                  wr_gnt_o,

    output logic                  ram_req_o,
    output logic                  ram_write_o,
    output logic [ADDR_WIDTH-1:0] ram_addr_o,
    output logic [DATA_WIDTH-1:0] ram_wdata_o,
    output logic [BE_WIDTH-1:0]   ram_be_o,
    input  logic [DATA_WIDTH-1:0] ram_rdata_i
);

    localparam logic [ADDR_WIDTH-1:0] LAST_ADDR  = '1;
    localparam logic [STREAK_W-1:0]   STREAK_MAX = STREAK_W'(MAX_WR_STREAK);

    // Saturating increment of the write-streak counter.
    function automatic logic [STREAK_W-1:0] streak_sat_inc(input logic [STREAK_W-1:0] v);
        logic [STREAK_W-1:0] r;
        if (v >= STREAK_MAX) begin
            r = STREAK_MAX;
        end else begin
            r = v + 1'b1;
        end
        return r;
    endfunction

    arb_state_e            r_state;
    arb_state_e            w_state_nxt;
    logic [ADDR_WIDTH-1:0] r_init_cnt;
    logic [ADDR_WIDTH-1:0] w_init_cnt_nxt;
    logic [STREAK_W-1:0]   r_wr_streak;
    logic                  r_rd_pending_p1;
    logic                  w_rd_gnt;
    logic                  w_wr_gnt;
    logic                  w_rd_starved;

    // A read that has watched MAX_WR_STREAK writes go by must win next.
    assign w_rd_starved = (r_wr_streak == STREAK_MAX);

    // Next-state, grant decode and RAM command mux (p0: request cycle).
    always_comb begin
        w_state_nxt    = r_state;
        w_init_cnt_nxt = r_init_cnt;
        w_rd_gnt       = 1'b0;
        w_wr_gnt       = 1'b0;
        ram_req_o      = 1'b0;
        ram_write_o    = 1'b0;
        ram_addr_o     = '0;
        ram_wdata_o    = '0;
        ram_be_o       = '0;

        case (r_state)
            S_INIT: begin
                // Requesters keep req high; they simply see no grant here.
                ram_req_o   = 1'b1;
                ram_write_o = 1'b1;
                ram_addr_o  = r_init_cnt;
                ram_be_o    = '1;
                if (r_init_cnt == LAST_ADDR) begin
                    w_state_nxt    = S_ARB;
                    w_init_cnt_nxt = '0;
                end else begin
                    w_init_cnt_nxt = r_init_cnt + 1'b1;
                end
            end

            S_ARB: begin
                if (init_i) begin
                    // Sweep request outranks both requesters this cycle.
                    w_state_nxt = S_INIT;
                end else if (wr_req_i && (!rd_req_i || !w_rd_starved)) begin
                    w_wr_gnt = 1'b1;
                end else if (rd_req_i) begin
                    w_rd_gnt = 1'b1;
                end

                if (w_wr_gnt) begin
                    ram_req_o   = 1'b1;
                    ram_write_o = 1'b1;
                    ram_addr_o  = wr_addr_i;
                    ram_wdata_o = wr_wdata_i;
                    ram_be_o    = wr_be_i;
                end else if (w_rd_gnt) begin
                    ram_req_o   = 1'b1;
                    ram_addr_o  = rd_addr_i;
                end
            end

            default: begin
                w_state_nxt    = S_INIT;
                w_init_cnt_nxt = '0;
            end
        endcase
    end

    // State and sweep-address register; reset restarts the sweep at 0.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state    <= S_INIT;
            r_init_cnt <= '0;
        end else begin
            r_state    <= w_state_nxt;
            r_init_cnt <= w_init_cnt_nxt;
        end
    end

    // Count consecutive write grants that a waiting read had to yield to.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wr_streak <= '0;
        end else if (w_rd_gnt || !rd_req_i) begin
            r_wr_streak <= '0;
        end else if (w_wr_gnt) begin
            r_wr_streak <= streak_sat_inc(r_wr_streak);
        end
    end

    // p0 -> p1: RAM read latency is one cycle; track which cycle owns data.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_rd_pending_p1 <= 1'b0;
        end else begin
            r_rd_pending_p1 <= w_rd_gnt;
        end
    end

    assign init_busy_o = (r_state == S_INIT);
    assign rd_gnt_o    = w_rd_gnt;
    assign wr_gnt_o    = w_wr_gnt;
    assign rd_rvalid_o = r_rd_pending_p1;
    assign rd_rdata_o  = ram_rdata_i;

endmodule

// File: tb/tb_icache_data_ram_arb.sv
// Scoreboard bench for icache_data_ram_arb with a behavioural 1-cycle RAM.
module tb_icache_data_ram_arb;

    localparam int DW = 64;
    localparam int AW = 7;
    localparam int BW = 8;
    localparam logic [DW-1:0] PRESET = 64'hA5A5_A5A5_A5A5_A5A5;

    typedef struct packed {
        logic          wr;
        logic [AW-1:0] addr;
        logic [DW-1:0] data;
        logic [BW-1:0] be;
    } gnt_t;

    logic          clk = 1'b0;
    logic          rst;
    logic          init_i;
    logic          init_busy_o;
    logic          rd_req_i;
    logic [AW-1:0] rd_addr_i;
    logic          rd_gnt_o;
    logic          rd_rvalid_o;
    logic [DW-1:0] rd_rdata_o;
    logic          wr_req_i;
    logic [AW-1:0] wr_addr_i;
    logic [DW-1:0] wr_wdata_i;
    logic [BW-1:0] wr_be_i;
    logic          wr_gnt_o;
    logic          ram_req_o;
    logic          ram_write_o;
    logic [AW-1:0] ram_addr_o;
    logic [DW-1:0] ram_wdata_o;
    logic [BW-1:0] ram_be_o;
    logic [DW-1:0] ram_rdata_i;

    logic          fill;
    logic [DW-1:0] mem [0:(1<<AW)-1];

    gnt_t          q_gnt[$];
    logic [DW-1:0] q_rd[$];

    int n_vec = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    icache_data_ram_arb #(
        .DATA_WIDTH(DW), .ADDR_WIDTH(AW), .BE_WIDTH(BW), .MAX_WR_STREAK(4)
    ) dut (
        .clk(clk), .rst(rst),
        .init_i(init_i), .init_busy_o(init_busy_o),
        .rd_req_i(rd_req_i), .rd_addr_i(rd_addr_i), .rd_gnt_o(rd_gnt_o),
        .rd_rvalid_o(rd_rvalid_o), .rd_rdata_o(rd_rdata_o),
        .wr_req_i(wr_req_i), .wr_addr_i(wr_addr_i), .wr_wdata_i(wr_wdata_i),
        .wr_be_i(wr_be_i), .wr_gnt_o(wr_gnt_o),
        .ram_req_o(ram_req_o), .ram_write_o(ram_write_o), .ram_addr_o(ram_addr_o),
        .ram_wdata_o(ram_wdata_o), .ram_be_o(ram_be_o), .ram_rdata_i(ram_rdata_i)
    );

    function automatic logic [DW-1:0] merge(input logic [DW-1:0] old, input logic [DW-1:0] nw,
                                            input logic [BW-1:0] be);
        logic [DW-1:0] r;
        r = old;
        for (int b = 0; b < BW; b++) if (be[b]) r[b*8 +: 8] = nw[b*8 +: 8];
        return r;
    endfunction

    // Single-port RAM, one-cycle read latency, preset to a non-zero pattern.
    always @(posedge clk) begin
        if (fill) begin
            for (int i = 0; i < (1 << AW); i++) mem[i] <= PRESET;
        end else if (ram_req_o) begin
            if (ram_write_o) mem[ram_addr_o] <= merge(mem[ram_addr_o], ram_wdata_o, ram_be_o);
            else             ram_rdata_i     <= mem[ram_addr_o];
        end
    end

    task automatic chk(input string nm, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    // Monitor: pops expected grants and read responses as the DUT shows them.
    always @(negedge clk) begin
        if (rst === 1'b0) begin
            if (rd_rvalid_o) begin
                if (q_rd.size() == 0) chk("rvalid_unexpected", 64'd1, 64'd0);
                else                  chk("rd_rdata", rd_rdata_o, q_rd.pop_front());
            end
            if (!init_busy_o && ram_req_o) begin
                if (q_gnt.size() == 0) begin
                    chk("grant_unexpected", {57'd0, ram_addr_o}, 64'hFFFF_FFFF_FFFF_FFFF);
                end else begin
                    gnt_t e;
                    e = q_gnt.pop_front();
                    chk("gnt_flags", {62'd0, rd_gnt_o, wr_gnt_o}, e.wr ? 64'd1 : 64'd2);
                    chk("ram_write", {63'd0, ram_write_o}, {63'd0, e.wr});
                    chk("ram_addr", {57'd0, ram_addr_o}, {57'd0, e.addr});
                    if (e.wr) begin
                        chk("ram_wdata", ram_wdata_o, e.data);
                        chk("ram_be", {56'd0, ram_be_o}, {56'd0, e.be});
                    end
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_write(input logic [AW-1:0] a, input logic [DW-1:0] d, input logic [BW-1:0] be);
        q_gnt.push_back('{wr: 1'b1, addr: a, data: d, be: be});
        wr_req_i = 1'b1; wr_addr_i = a; wr_wdata_i = d; wr_be_i = be;
        tick();
        wr_req_i = 1'b0;
    endtask

    task automatic do_read(input logic [AW-1:0] a, input logic [DW-1:0] exp);
        q_gnt.push_back('{wr: 1'b0, addr: a, data: '0, be: '0});
        q_rd.push_back(exp);
        rd_req_i = 1'b1; rd_addr_i = a;
        tick();
        rd_req_i = 1'b0;
    endtask

    task automatic count_busy(output int n);
        n = 0;
        for (int c = 0; c < 1000; c++) begin
            @(negedge clk);
            if (!init_busy_o) break;
            n++;
        end
    endtask

    initial begin
        int n;
        int gseen;
        logic found;

        rst = 1'b1; fill = 1'b1; init_i = 1'b0;
        rd_req_i = 1'b1; rd_addr_i = 7'd3;
        wr_req_i = 1'b1; wr_addr_i = 7'd4; wr_wdata_i = 64'h1; wr_be_i = 8'hFF;
        tick();
        fill = 1'b0;

        // Reset values with both requesters asserted.
        @(negedge clk);
        chk("rst_busy", {63'd0, init_busy_o}, 64'd1);
        chk("rst_rvalid", {63'd0, rd_rvalid_o}, 64'd0);
        chk("rst_gnts", {62'd0, rd_gnt_o, wr_gnt_o}, 64'd0);
        chk("rst_ram_addr", {57'd0, ram_addr_o}, 64'd0);
        rd_req_i = 1'b0; wr_req_i = 1'b0;
        tick();
        rst = 1'b0;
        #1;
        chk("sweep_write", {63'd0, ram_write_o}, 64'd1);
        chk("sweep_wdata", ram_wdata_o, 64'd0);
        chk("sweep_be", {56'd0, ram_be_o}, 64'hFF);
        count_busy(n);
        chk("sweep_len_reset", 64'(n), 64'd128);
        tick();

        // Sweep zeroed the whole preset bank.
        do_read(7'd0, 64'd0);
        do_read(7'd64, 64'd0);
        do_read(7'd127, 64'd0);

        // Simple write/read, partial byte-enable, same-address back-to-back.
        do_write(7'd5, 64'h0000_0000_DEAD_BEEF, 8'hFF);
        do_read(7'd5, 64'h0000_0000_DEAD_BEEF);
        do_write(7'd9, 64'h1111_2222_3333_4444, 8'h0F);
        do_read(7'd9, 64'h0000_0000_3333_4444);
        do_write(7'd20, 64'hCAFE_F00D_1234_5678, 8'hFF);
        do_read(7'd20, 64'hCAFE_F00D_1234_5678);
        tick();

        // Both requesters held: W,W,W,W,R repeating.
        for (int k = 0; k < 15; k++) begin
            if (k % 5 == 4) begin
                q_gnt.push_back('{wr: 1'b0, addr: 7'd5, data: '0, be: '0});
                q_rd.push_back(64'h0000_0000_DEAD_BEEF);
            end else begin
                q_gnt.push_back('{wr: 1'b1, addr: 7'd30, data: 64'h3030_3030_0000_0000 | 64'(k), be: 8'hFF});
            end
        end
        rd_req_i = 1'b1; rd_addr_i = 7'd5; wr_req_i = 1'b1; wr_addr_i = 7'd30; wr_be_i = 8'hFF;
        for (int k = 0; k < 15; k++) begin
            wr_wdata_i = 64'h3030_3030_0000_0000 | 64'(k);
            tick();
        end
        rd_req_i = 1'b0; wr_req_i = 1'b0;
        tick();

        // Read in the cycle just before an init pulse; init held with rd_req.
        do_write(7'd7, 64'h7777_0000_0000_7777, 8'hFF);
        do_read(7'd7, 64'h7777_0000_0000_7777);
        q_gnt.push_back('{wr: 1'b0, addr: 7'd5, data: '0, be: '0});
        q_rd.push_back(64'd0);
        init_i = 1'b1; rd_req_i = 1'b1; rd_addr_i = 7'd5;
        tick();
        init_i = 1'b0;
        n = 0; gseen = 0;
        for (int c = 0; c < 1000; c++) begin
            @(negedge clk);
            if (!init_busy_o) break;
            n++;
            if (rd_gnt_o || wr_gnt_o) gseen++;
            if (n == 50) init_i = 1'b1;
            if (n == 51) init_i = 1'b0;
        end
        chk("sweep_len_init", 64'(n), 64'd128);
        chk("sweep_no_grants", 64'(gseen), 64'd0);
        tick();
        rd_req_i = 1'b0;
        tick();

        // Reset at sweep address 40 restarts the sweep from 0.
        do_write(7'd100, 64'h0100_0100_0100_0100, 8'hFF);
        init_i = 1'b1;
        tick();
        init_i = 1'b0;
        found = 1'b0;
        for (int c = 0; c < 300; c++) begin
            @(negedge clk);
            if (init_busy_o && ram_addr_o == 7'd40) begin
                found = 1'b1;
                break;
            end
        end
        chk("sweep_reach_40", {63'd0, found}, 64'd1);
        rst = 1'b1;
        #1;
        chk("midrst_busy", {63'd0, init_busy_o}, 64'd1);
        chk("midrst_addr", {57'd0, ram_addr_o}, 64'd0);
        tick();
        tick();
        rst = 1'b0;
        count_busy(n);
        chk("sweep_len_midrst", 64'(n), 64'd128);
        tick();
        do_read(7'd100, 64'd0);
        do_read(7'd30, 64'd0);

        repeat (4) tick();
        chk("gnt_queue_empty", 64'(q_gnt.size()), 64'd0);
        chk("rd_queue_empty", 64'(q_rd.size()), 64'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/icache_data_ram_arb.md
Name: icache_data_ram_arb

Overview:
Arbiter and sequencer for one single-port L1.5 instruction-cache data RAM bank, sized 2**ADDR_WIDTH x DATA_WIDTH with one-cycle read latency.
- Shares the bank between the lookup read path and the refill write path.
- Write-priority arbitration, with a starvation guard for reads.
- Hardware init sweep that zeroes the whole bank after reset or on demand.
- Sits between the cache controller and the data RAM wrapper.

Parameters:
DATA_WIDTH, 64, RAM word width in bits.
ADDR_WIDTH, 7, RAM word address width; depth = 2**ADDR_WIDTH.
BE_WIDTH, DATA_WIDTH/8, byte-enable width.
MAX_WR_STREAK, 4, maximum consecutive write grants while a read is pending; range 1..15.

Ports:
clk  in  1  clock
rst  in  1  asynchronous active-high reset
init_i  in  1  pulse; start a zeroing sweep of the bank
init_busy_o  out  1  sweep in progress
rd_req_i  in  1  read request
rd_addr_i  in  ADDR_WIDTH  read address
rd_gnt_o  out  1  read granted this cycle
rd_rvalid_o  out  1  read data valid (one cycle after grant)
rd_rdata_o  out  DATA_WIDTH  read data
wr_req_i  in  1  write request
wr_addr_i  in  ADDR_WIDTH  write address
wr_wdata_i  in  DATA_WIDTH  write data
wr_be_i  in  BE_WIDTH  write byte enables
wr_gnt_o  out  1  write granted this cycle
ram_req_o  out  1  RAM request
ram_write_o  out  1  RAM write enable
ram_addr_o  out  ADDR_WIDTH  RAM address
ram_wdata_o  out  DATA_WIDTH  RAM write data
ram_be_o  out  BE_WIDTH  RAM byte enables
ram_rdata_i  in  DATA_WIDTH  RAM read data, valid one cycle after a read request

Behaviour:
- Clocking and reset: one clock, clk; reset rst is asynchronous and active-high.
- Reset values:
  - FSM enters S_INIT with init_cnt=0.
  - wr_streak=0, rd_pending_q=0.
  - rd_rvalid_o=0; rd_gnt_o=wr_gnt_o=0.
  - init_busy_o=1 (during reset and the following sweep).
  - Registered outputs zero; ram_* outputs follow the FSM decode below.
- FSM states: S_INIT, S_ARB.
- S_INIT:
  - Drives ram_req_o=1, ram_write_o=1, ram_addr_o=init_cnt, ram_wdata_o=0, ram_be_o=all ones.
  - rd_gnt_o=wr_gnt_o=0; requests are held off, not dropped. Requesters keep req asserted, per the PULP req/gnt rule.
  - init_cnt increments every cycle.
  - After writing address 2**ADDR_WIDTH-1: go to S_ARB and clear init_cnt. The sweep takes exactly 2**ADDR_WIDTH cycles.
  - init_i asserted while in S_INIT is ignored; the sweep does not restart.
- S_ARB, grant is combinational in the same cycle:
  - Neither req: ram_req_o=0.
  - Only one req: that request is granted.
  - Both req: write wins unless wr_streak==MAX_WR_STREAK, in which case read wins.
  - Read grant: ram_req_o=1, ram_write_o=0, ram_addr_o=rd_addr_i.
  - Write grant: ram_req_o=1, ram_write_o=1; address, data and be taken from wr_*.
  - init_i=1 in S_ARB: no grant this cycle; next state S_INIT. init_i takes priority over both requesters.
- wr_streak counter (4-bit, saturating at MAX_WR_STREAK):
  - Increments on a write grant while rd_req_i=1.
  - Clears on any read grant, or on any cycle with rd_req_i=0.
  - Effect: a pending read waits at most MAX_WR_STREAK cycles.
- Read response:
  - rd_pending_q <= read grant.
  - rd_rvalid_o = rd_pending_q; rd_rdata_o = ram_rdata_i, passed through unregistered.
  - Latency is exactly 1 cycle, with no backpressure; the requester must sink data.
  - Back-to-back read grants produce back-to-back rvalid.
- Same-address hazard: a write granted in cycle N followed by a read granted in N+1 returns the new data. This is a RAM property; no forwarding logic.
- Reset mid-sweep: the sweep restarts from address 0.
- A read granted in the last S_ARB cycle before S_INIT still delivers rvalid in the next cycle.

Decomposition:
- Package icache_data_arb_pkg holds:
  - typedef arb_state_e {S_INIT, S_ARB};
  - localparam STREAK_W=4.
- No sub-module; a single flat module is natural.

Test Plan:
- Reset release, ADDR_WIDTH=7 -> init_busy_o=1 for 128 cycles; ram writes 0 to addresses 0..127 with be=8'hFF; then init_busy_o=0 and grants are possible.
- Read-only, rd_addr=5 after writing 64'hDEAD_BEEF to 5 -> rd_gnt_o=1 in cycle N; rd_rvalid_o=1 and rdata=64'hDEAD_BEEF in N+1.
- rd_req and wr_req held continuously, MAX_WR_STREAK=4 -> grant pattern W,W,W,W,R repeating; rvalid exactly once per 5 cycles.
- Write to 9 with be=8'h0F, data 64'h1111_2222_3333_4444, over 0; then read 9 -> rdata=64'h0000_0000_3333_4444.
- init_i pulse while rd_req=1 -> zero grants for 128 cycles; the read is granted on the first S_ARB cycle; a second init_i mid-sweep does not extend the busy period.
- Assert rst at sweep address 40 -> init_busy_o stays 1; the sweep restarts at 0 and completes in 128 cycles after release.
